// File: rtl/sam_pkg.sv
// Shared types and helpers for the sequential shift-and-accumulate multiplier.
package sam_pkg;

  localparam int unsigned SAM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    SIGN,
    DONE
  } sam_state_e;

  // Bits needed to count 0 .. n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sam_step.sv
// One shift-add step: conditionally add the multiplicand, then shift both operands.
module sam_step
  import sam_pkg::*;
#(
  parameter int unsigned WIDTH = SAM_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] ma,
  input  logic [WIDTH-1:0]   mb,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] ma_nxt,
  output logic [WIDTH-1:0]   mb_nxt
);

  logic [2*WIDTH-1:0] addend;

  // Ripple-carry add of the gated multiplicand into the accumulator.
  always_comb begin
    logic carry;
    carry   = 1'b0;
    addend  = mb[0] ? ma : '0;
    acc_nxt = '0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      acc_nxt[i] = acc[i] ^ addend[i] ^ carry;
      carry      = (acc[i] & addend[i]) | (carry & (acc[i] ^ addend[i]));
    end
  end

  assign ma_nxt = {ma[2*WIDTH-2:0], 1'b0};
  assign mb_nxt = {1'b0, mb[WIDTH-1:1]};

endmodule

// File: rtl/sam_seq_ctrl.sv
// Sequential signed multiplier: one multiplier bit per cycle, sign fixed up at the end.
module sam_seq_ctrl
  import sam_pkg::*;
#(
  parameter int unsigned WIDTH      = SAM_WIDTH,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sam_state_e         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] ma;
  logic [WIDTH-1:0]   mb;
  logic               neg;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] ma_nxt;
  logic [WIDTH-1:0]   mb_nxt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign a_mag       = mag(a);
  assign b_mag       = mag(b);
  assign start_ready = (state == IDLE) | ((state == DONE) & res_ready);
  assign busy        = (state == ITER) | (state == SIGN);

  sam_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc    (acc),
    .ma     (ma),
    .mb     (mb),
    .acc_nxt(acc_nxt),
    .ma_nxt (ma_nxt),
    .mb_nxt (mb_nxt)
  );

  // Controller FSM with operand, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      result    <= '0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            ma    <= {{WIDTH{1'b0}}, a_mag};
            mb    <= b_mag;
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc   <= '0;
            count <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          acc   <= acc_nxt;
          ma    <= ma_nxt;
          mb    <= mb_nxt;
          count <= count + 1'b1;
          // Once the remaining multiplier bits are zero no further add can occur.
          if ((count == LAST) || (EARLY_EXIT && (mb_nxt == '0))) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          result    <= neg ? (~acc + 1'b1) : acc;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (start_valid) begin
              // Back-to-back issue: capture the next operands in the same cycle.
              ma    <= {{WIDTH{1'b0}}, a_mag};
              mb    <= b_mag;
              neg   <= a[WIDTH-1] ^ b[WIDTH-1];
              acc   <= '0;
              count <= '0;
              state <= ITER;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
